// File: rtl/dmem_bridge_if.sv
// Purpose : bundles the MEM-stage request/response and SRAM port signals of dmem_bridge.
// Latency : n/a (wires only).
// Backpressure: n/a; the stall/err handshake is carried by mem_stall and mem_err.
//
// Signal summary:
//   mem_ren/mem_wen/mem_addr/mem_dout : MEM-stage request (driven by the pipeline)
//   mem_din/mem_stall/mem_err         : response to the pipeline (driven by the bridge)
//   ram_en/ram_we/ram_addr/ram_wdata  : SRAM command (driven by the bridge)
//   ram_rdata                         : SRAM read data (driven by the SRAM)
// Modports: slave = bridge view, master = pipeline + SRAM environment view.
interface dmem_bridge_if #(
    parameter int ADDR_WIDTH = 10
);
    logic                  mem_ren;
    logic                  mem_wen;
    logic [31:0]           mem_addr;
    logic [31:0]           mem_dout;
    logic [31:0]           mem_din;
    logic                  mem_stall;
    logic                  mem_err;
    logic                  ram_en;
    logic                  ram_we;
    logic [ADDR_WIDTH-1:0] ram_addr;
    logic [31:0]           ram_wdata;
    logic [31:0]           ram_rdata;

    modport slave (
        input  mem_ren, mem_wen, mem_addr, mem_dout, ram_rdata,
        output mem_din, mem_stall, mem_err, ram_en, ram_we, ram_addr, ram_wdata
    );

    modport master (
        output mem_ren, mem_wen, mem_addr, mem_dout, ram_rdata,
        input  mem_din, mem_stall, mem_err, ram_en, ram_we, ram_addr, ram_wdata
    );
endinterface

// File: rtl/dmem_bridge.sv
// Purpose : MEM-stage data-memory access unit in front of a fixed-latency word SRAM.
// Latency : loads RD_LATENCY+2 cycles (data in DONE), stores 2 cycles, rejects 1 cycle + err pulse.
// Backpressure: mem_stall holds IF..MEM from the load request cycle until the cycle before DONE.
//
// Ports:
//   i_clk  : core clock, single domain
//   i_rst  : synchronous active-high reset
//   bus    : dmem_bridge_if.slave -- pipeline request/response and SRAM command/data
module dmem_bridge #(
    parameter int ADDR_WIDTH = 10,
    parameter int RD_LATENCY = 2     // 1..15, must fit the 4-bit wait counter
) (
    input  logic           i_clk,
    input  logic           i_rst,
    dmem_bridge_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      r_state;
    logic [3:0]  r_cnt;
    logic [31:0] r_din;
    logic        r_err;

    logic        w_req;
    logic        w_bad;
    logic        w_ok;

    // Any address bit above the SRAM window, or a non-word-aligned byte
    // offset, makes the access illegal. The shift form stays well defined
    // even when the window reaches the top of the 32-bit space.
    assign w_req = bus.mem_ren | bus.mem_wen;
    assign w_bad = (bus.mem_addr[1:0] != 2'b00) |
                   ((bus.mem_addr >> (ADDR_WIDTH + 2)) != 32'd0);
    assign w_ok  = w_req & ~w_bad;

    // Command and stall are combinational so a load reaches the SRAM in the
    // same cycle the pipeline presents it; only IDLE ever issues a command,
    // which is what keeps the still-visible request from being replayed in DONE.
    always_comb begin
        bus.ram_en    = 1'b0;
        bus.ram_we    = 1'b0;
        bus.mem_stall = 1'b0;
        bus.ram_addr  = bus.mem_addr[ADDR_WIDTH+1:2];
        bus.ram_wdata = bus.mem_dout;
        case (r_state)
            IDLE: begin
                bus.ram_en    = w_ok;
                bus.ram_we    = w_ok & bus.mem_wen;
                // A write wins over a simultaneous read, so only a pure read stalls.
                bus.mem_stall = w_ok & ~bus.mem_wen;
            end
            WAIT: begin
                bus.mem_stall = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign bus.mem_din = r_din;
    assign bus.mem_err = r_err;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            // Dropping out of WAIT here abandons the in-flight SRAM read;
            // its data simply never gets sampled.
            r_state <= IDLE;
            r_cnt   <= 4'd0;
            r_din   <= 32'd0;
            r_err   <= 1'b0;
        end else begin
            r_err <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_ok && bus.mem_wen) begin
                        r_state <= DONE;
                    end else if (w_ok) begin
                        // Counts the cycles still to go before ram_rdata is valid.
                        r_cnt   <= 4'(RD_LATENCY - 1);
                        r_state <= WAIT;
                    end else if (w_req) begin
                        r_err <= 1'b1;
                        r_din <= 32'd0;
                    end
                end
                WAIT: begin
                    if (r_cnt == 4'd0) begin
                        r_din   <= bus.ram_rdata;
                        r_state <= DONE;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_bridge.sv
// Purpose : self-checking bench for dmem_bridge against a fixed-latency SRAM model.
// Latency : checks every cycle of each load/store/reject against the expected timeline.
// Backpressure: expects mem_stall exactly over cycles 0..RD_LATENCY of each load.
module tb_dmem_bridge;

    localparam int AW = 10;
    localparam int L  = 2;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    dmem_bridge_if #(.ADDR_WIDTH(AW)) bus ();

    dmem_bridge #(.ADDR_WIDTH(AW), .RD_LATENCY(L)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus.slave)
    );

    // ---------------- SRAM environment model ----------------
    // Data launched by an ram_en read cycle is visible on ram_rdata exactly
    // L cycles later; any other cycle shows a garbage pattern.
    logic [31:0] sram [1024];
    logic [31:0] pd   [L];
    logic [L-1:0] pv;
    logic        init_done = 1'b0;

    function automatic logic [31:0] init_word(input int i);
        return 32'h1000_0000 + 32'(i) * 32'h0001_0003;
    endfunction

    always @(posedge clk) begin
        if (!init_done) begin
            for (int i = 0; i < 1024; i++) sram[i] <= init_word(i);
            init_done <= 1'b1;
        end else if (bus.ram_en === 1'b1 && bus.ram_we === 1'b1) begin
            sram[bus.ram_addr] <= bus.ram_wdata;
        end
        pv[0] <= (bus.ram_en === 1'b1) && (bus.ram_we !== 1'b1);
        pd[0] <= sram[bus.ram_addr];
        for (int i = 1; i < L; i++) begin
            pv[i] <= pv[i-1];
            pd[i] <= pd[i-1];
        end
    end

    assign bus.ram_rdata = pv[L-1] ? pd[L-1] : 32'hBAD0_BAD0;

    // ---------------- reference model ----------------
    logic [31:0] refmem [1024];
    logic [31:0] exp_din;
    int n_assert = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic ren, input logic wen, input logic [31:0] a, input logic [31:0] d);
        bus.mem_ren  = ren;
        bus.mem_wen  = wen;
        bus.mem_addr = a;
        bus.mem_dout = d;
    endtask

    // Load: stall over cycles 0..L, one SRAM strobe in cycle 0, data in cycle L+1.
    task automatic do_read(input logic [31:0] a);
        drive(1'b1, 1'b0, a, $urandom);
        for (int c = 0; c <= L; c++) begin
            @(negedge clk);
            chk("rd_stall", {31'd0, bus.mem_stall}, 32'd1);
            chk("rd_en", {31'd0, bus.ram_en}, (c == 0) ? 32'd1 : 32'd0);
            if (c == 0) begin
                chk("rd_we", {31'd0, bus.ram_we}, 32'd0);
                chk("rd_addr", {22'd0, bus.ram_addr}, {22'd0, a[11:2]});
            end
            chk("rd_hold", bus.mem_din, exp_din);
            next_cycle();
        end
        // DONE: request still on the inputs, must not be re-issued.
        exp_din = refmem[a[11:2]];
        @(negedge clk);
        chk("rd_done_stall", {31'd0, bus.mem_stall}, 32'd0);
        chk("rd_done_en", {31'd0, bus.ram_en}, 32'd0);
        chk("rd_data", bus.mem_din, exp_din);
        chk("rd_err", {31'd0, bus.mem_err}, 32'd0);
        next_cycle();
        drive(1'b0, 1'b0, 32'd0, 32'd0);
    endtask

    // Store (optionally with mem_ren also high, where the write wins).
    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic both);
        drive(both, 1'b1, a, d);
        @(negedge clk);
        chk("wr_en", {31'd0, bus.ram_en}, 32'd1);
        chk("wr_we", {31'd0, bus.ram_we}, 32'd1);
        chk("wr_addr", {22'd0, bus.ram_addr}, {22'd0, a[11:2]});
        chk("wr_data", bus.ram_wdata, d);
        chk("wr_stall", {31'd0, bus.mem_stall}, 32'd0);
        refmem[a[11:2]] = d;
        next_cycle();
        @(negedge clk);
        chk("wr_done_en", {31'd0, bus.ram_en}, 32'd0);
        chk("wr_done_stall", {31'd0, bus.mem_stall}, 32'd0);
        chk("wr_din", bus.mem_din, exp_din);
        next_cycle();
        drive(1'b0, 1'b0, 32'd0, 32'd0);
    endtask

    // Rejected access: no SRAM strobe, no stall, one-cycle err, load data cleared.
    task automatic do_bad(input logic [31:0] a, input logic wen);
        drive(~wen, wen, a, $urandom);
        @(negedge clk);
        chk("bad_en", {31'd0, bus.ram_en}, 32'd0);
        chk("bad_stall", {31'd0, bus.mem_stall}, 32'd0);
        chk("bad_err_pre", {31'd0, bus.mem_err}, 32'd0);
        next_cycle();
        drive(1'b0, 1'b0, 32'd0, 32'd0);
        exp_din = 32'd0;
        @(negedge clk);
        chk("bad_err", {31'd0, bus.mem_err}, 32'd1);
        chk("bad_din", bus.mem_din, exp_din);
        next_cycle();
        @(negedge clk);
        chk("bad_err_post", {31'd0, bus.mem_err}, 32'd0);
        next_cycle();
    endtask

    task automatic do_idle();
        drive(1'b0, 1'b0, $urandom, $urandom);
        @(negedge clk);
        chk("idle_stall", {31'd0, bus.mem_stall}, 32'd0);
        chk("idle_en", {31'd0, bus.ram_en}, 32'd0);
        chk("idle_err", {31'd0, bus.mem_err}, 32'd0);
        chk("idle_din", bus.mem_din, exp_din);
        next_cycle();
    endtask

    initial begin
        logic [31:0] a;
        for (int i = 0; i < 1024; i++) refmem[i] = init_word(i);
        exp_din = 32'd0;
        rst = 1'b1;
        drive(1'b0, 1'b0, 32'd0, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state with idle inputs.
        @(negedge clk);
        chk("rst_din", bus.mem_din, 32'd0);
        chk("rst_stall", {31'd0, bus.mem_stall}, 32'd0);
        chk("rst_en", {31'd0, bus.ram_en}, 32'd0);
        chk("rst_err", {31'd0, bus.mem_err}, 32'd0);
        next_cycle();

        do_write(32'h10, 32'hDEADBEEF, 1'b0);
        do_read(32'h10);
        do_bad(32'h13, 1'b0);
        do_bad(32'h1000, 1'b0);
        do_write(32'h8, 32'hCAFEF00D, 1'b1);
        do_read(32'h8);

        // Reset while the load is waiting on the SRAM.
        drive(1'b1, 1'b0, 32'h10, 32'd0);
        @(negedge clk);
        chk("rw_stall0", {31'd0, bus.mem_stall}, 32'd1);
        next_cycle();
        rst = 1'b1;
        drive(1'b0, 1'b0, 32'd0, 32'd0);
        @(negedge clk);
        chk("rw_stall1", {31'd0, bus.mem_stall}, 32'd1);
        next_cycle();
        rst = 1'b0;
        exp_din = 32'd0;
        @(negedge clk);
        chk("rw_idle_stall", {31'd0, bus.mem_stall}, 32'd0);
        chk("rw_idle_din", bus.mem_din, 32'd0);
        chk("rw_idle_err", {31'd0, bus.mem_err}, 32'd0);
        chk("rw_idle_en", {31'd0, bus.ram_en}, 32'd0);
        next_cycle();
        do_read(32'h10);

        // Randomized mix over a small window so loads hit earlier stores.
        for (int n = 0; n < 80; n++) begin
            a = {20'd0, 8'(0), 2'(0), 2'b00};
            a[5:2] = 4'($urandom_range(0, 15));
            case ($urandom_range(0, 4))
                0: do_write(a, $urandom, 1'b0);
                1: do_write(a, $urandom, 1'b1);
                2: do_read(a);
                3: begin
                    if ($urandom_range(0, 1) == 1)
                        a[1:0] = 2'($urandom_range(1, 3));
                    else
                        a = a | 32'h1000 | ($urandom & 32'hFFFF_F000);
                    do_bad(a, 1'($urandom_range(0, 1)));
                end
                default: do_idle();
            endcase
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
